// File: rtl/c2h_arb_pkg.sv
// Shared definitions for the C2H packet arbiter: FSM encoding, header layout
// and the header builder used by the arbiter top.
package c2h_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int          HDR_SEQ_LSB   = 0;
  localparam int          HDR_SRC_LSB   = 16;
  localparam int          HDR_MAGIC_LSB = 32;
  localparam int          HDR_W         = 48;
  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA5C3;

  // Low 48 bits of the header beat; bits [31:24] and everything above stay zero.
  function automatic logic [HDR_W-1:0] build_hdr(input logic [15:0] seq,
                                                 input logic [7:0]  src,
                                                 input logic [15:0] magic);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_SEQ_LSB   +: 16] = seq;
    h[HDR_SRC_LSB   +: 8]  = src;
    h[HDR_MAGIC_LSB +: 16] = magic;
    return h;
  endfunction

endpackage

// File: rtl/c2h_pkt_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_last, wrapping
// modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_grant,
  output logic          o_valid
);

  logic [IW-1:0] w_grant;
  logic          w_valid;

  // Scan N positions starting one past the previous grant.
  always_comb begin
    int  idx;
    logic hit;
    w_grant = '0;
    w_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx     = int'(i_last) + k;
      idx     = (idx >= N) ? (idx - N) : idx;
      hit     = !w_valid && i_req[idx];
      w_grant = hit ? IW'(idx) : w_grant;
      w_valid = w_valid | hit;
    end
  end

  assign o_grant = w_grant;
  assign o_valid = w_valid;

endmodule

// File: rtl/c2h_pkt_arbiter.sv
// Multiplexes NUM_SRC AXI-Stream sources onto one XDMA C2H stream, prefixing
// each packet with a header beat carrying a per-source sequence number.
module c2h_pkt_arbiter
  import c2h_arb_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter int          DATA_W    = 128,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
  localparam int         KEEP_W    = DATA_W / 8,
  localparam int         SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      user_clk,
  input  logic                      user_rst,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic                      busy,
  output logic [SRC_W-1:0]          cur_src,
  output logic [31:0]               pkt_cnt
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [SRC_W-1:0]          r_cur_src;
  logic [SRC_W-1:0]          r_last_grant;
  logic [NUM_SRC-1:0][15:0]  r_seq;
  logic [31:0]               r_pkt_cnt;
  logic [NUM_SRC-1:0]        w_req;
  logic [SRC_W-1:0]          w_pick;
  logic                      w_pick_vld;
  logic                      w_pkt_done;
  logic [HDR_W-1:0]          w_hdr;

  assign w_req = s_tvalid & src_en;
  assign w_hdr = build_hdr(r_seq[r_cur_src], 8'(r_cur_src), HDR_MAGIC);

  rr_arbiter #(
    .N  (NUM_SRC),
    .IW (SRC_W)
  ) u_rr (
    .i_req   (w_req),
    .i_last  (r_last_grant),
    .o_grant (w_pick),
    .o_valid (w_pick_vld)
  );

  // Next state and stream muxing; DATA is a zero-latency pass-through.
  always_comb begin
    w_state_nxt = r_state;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    m_tkeep     = '0;
    s_tready    = '0;
    w_pkt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) w_state_nxt = ST_HDR;
        else            w_state_nxt = ST_IDLE;
      end
      ST_HDR: begin
        m_tvalid             = 1'b1;
        m_tkeep              = '1;
        m_tdata[HDR_W-1:0]   = w_hdr;
        if (m_tready) w_state_nxt = ST_DATA;
        else          w_state_nxt = ST_HDR;
      end
      ST_DATA: begin
        m_tdata             = s_tdata[r_cur_src*DATA_W +: DATA_W];
        m_tkeep             = s_tkeep[r_cur_src*KEEP_W +: KEEP_W];
        m_tvalid            = s_tvalid[r_cur_src];
        m_tlast             = s_tlast[r_cur_src];
        s_tready[r_cur_src] = m_tready;
        w_pkt_done          = s_tvalid[r_cur_src] & s_tlast[r_cur_src] & m_tready;
        if (w_pkt_done) w_state_nxt = ST_IDLE;
        else            w_state_nxt = ST_DATA;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant, sequence and packet bookkeeping; only a completed packet updates counters.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_cur_src    <= '0;
      r_last_grant <= SRC_W'(NUM_SRC - 1);
      r_seq        <= '0;
      r_pkt_cnt    <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && w_pick_vld) r_cur_src <= w_pick;
      if (w_pkt_done) begin
        r_seq[r_cur_src] <= r_seq[r_cur_src] + 16'd1;
        r_pkt_cnt        <= r_pkt_cnt + 32'd1;
        r_last_grant     <= r_cur_src;
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign cur_src = r_cur_src;
  assign pkt_cnt = r_pkt_cnt;

endmodule

// File: doc/c2h_pkt_arbiter.md
C2H_PKT_ARBITER -- requirements
Module: c2h_pkt_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of C2H stream requesters (2..8).
REQ-002 Parameter DATA_W, default 128, stream data width; KEEP_W = DATA_W/8 (16).
REQ-003 Parameter HDR_MAGIC, default 16'hA5C3, header marker word.
REQ-004 user_clk  in  1  sole clock, XDMA AXI clock domain.
REQ-005 user_rst  in  1  reset, asynchronous, active-high.
REQ-006 src_en  in  NUM_SRC  per-source enable, sampled only in IDLE.
REQ-007 s_tdata  in  NUM_SRC*DATA_W  source data, source i at [i*DATA_W +: DATA_W].
REQ-008 s_tkeep  in  NUM_SRC*KEEP_W  source byte enables, packed likewise.
REQ-009 s_tvalid / s_tlast  in  NUM_SRC each  source valid / end-of-packet.
REQ-010 s_tready  out  NUM_SRC  per-source ready.
REQ-011 m_tdata / m_tkeep  out  DATA_W / KEEP_W  to XDMA c2h_tdata / c2h_tkeep.
REQ-012 m_tvalid / m_tlast  out  1 each  to c2h_tvalid / c2h_tlast.
REQ-013 m_tready  in  1  from c2h_tready.
REQ-014 busy  out  1  high in HDR or DATA.
REQ-015 cur_src  out  clog2(NUM_SRC)  currently granted source.
REQ-016 pkt_cnt  out  32  total packets forwarded, wraps at 2^32.

Function
REQ-017 FSM states IDLE, HDR, DATA; transitions only on user_clk rising edge.
REQ-018 IDLE: m_tvalid=0, s_tready=0; req = s_tvalid & src_en; if req nonzero, grant first set bit searching from last_grant+1 modulo NUM_SRC, register cur_src, go HDR.
REQ-019 HDR: m_tvalid=1, m_tlast=0, m_tkeep all ones; m_tdata[15:0]=seq[cur_src], [23:16]=cur_src, [31:24]=0, [47:32]=HDR_MAGIC, upper bits 0.
REQ-020 HDR beat held stable while m_tready=0; on m_tready=1 go DATA.
REQ-021 DATA: m_tdata/m_tkeep/m_tvalid/m_tlast combinationally equal granted source's signals; s_tready[cur_src]=m_tready; all other s_tready=0; zero-cycle pass-through latency.
REQ-022 DATA beat with s_tvalid, s_tlast and m_tready all high: seq[cur_src]+1 (16-bit wrap FFFF->0000), pkt_cnt+1, last_grant=cur_src, go IDLE.
REQ-023 Grant locked for whole packet; src_en or other s_tvalid changes during HDR/DATA ignored.
REQ-024 Minimum one IDLE cycle between packets; back-to-back throughput per packet = N data beats + 2 cycles.
REQ-025 Source dropping s_tvalid mid-packet: m_tvalid follows low, FSM stays DATA; no timeout.
REQ-026 Simultaneous requests: strict round-robin, no source granted twice while another enabled source is waiting.
REQ-027 Single-beat packet (tlast on first data beat): HDR + 1 data beat, then IDLE.

Reset
REQ-028 user_rst asserted: state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, s_tready=0, busy=0, cur_src=0, all seq=0, pkt_cnt=0, last_grant=NUM_SRC-1 (source 0 first priority).
REQ-029 Reset mid-packet aborts packet immediately; no partial-packet completion or counter update.

Structure
REQ-030 Shared package c2h_arb_pkg holds FSM state enum, header field offsets, HDR_MAGIC default.
REQ-031 One sub-module rr_arbiter: combinational round-robin pick (req, last_grant -> grant index, valid).

Verification
REQ-032 Src0 only, 3-beat packet, m_tready=1 -> header 0x...A5C3_0000_0000, 3 data beats, tlast on third, pkt_cnt=1, seq[0]=1.
REQ-033 All 4 sources valid continuously, 2-beat packets -> grant order 0,1,2,3,0; headers carry src 0..3.
REQ-034 m_tready toggled 1010 during HDR/DATA -> header and data stable while stalled, no beat lost or duplicated.
REQ-035 src_en=4'b0010 with all s_tvalid high -> only source 1 granted; src_en cleared mid-packet -> packet completes.
REQ-036 Preload seq[2]=16'hFFFF via 65535 packets (or force) -> next header seq=FFFF, following header 0000.
REQ-037 user_rst asserted on second data beat -> next cycle m_tvalid=0, busy=0, pkt_cnt=0; after release src0 granted first.
